data_mem_controller: RTL and testbench
======================================

Name: data_mem_controller

Overview:
- On-chip data memory that serves the load/store unit's memory request/response interface.
- Sits directly downstream of the load/store unit: consumes its to_mem_* requests and produces the from_mem_* responses.
- Holds a byte-writable word array with fixed read-pipeline latency.
- Returns read responses in order, tagged with rs_id and reg_addr; a credit-limited response FIFO absorbs backpressure.

Parameters:
- RS_ID_WIDTH, 5, width of the reservation-station id tag carried with each request.
- MEM_WORDS, 1024, number of 32-bit words; must be a power of 2.
- READ_LATENCY, 1, cycles from request accept to data entering the response FIFO; legal range 1..4.
- RESP_DEPTH, 4, response FIFO depth; also the maximum number of outstanding reads.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- to_mem_valid  in  1  request valid
- to_mem_ready  out  1  request accepted when valid & ready
- to_mem_rs_id  in  RS_ID_WIDTH  tag returned with the read response
- to_mem_reg_addr  in  5  destination GPR, returned with the read response
- mem_address  in  32  byte address; bits [30:31] ignored
- mem_write_en  in  4  byte write enables; bit 0 = bits [0:7] (big-endian)
- mem_write_data  in  32  store data
- mem_read_en  in  4  byte read enables; nonzero marks a read
- from_mem_valid  out  1  response valid
- from_mem_ready  in  1  response consumed when valid & ready
- from_mem_rs_id  out  RS_ID_WIDTH  tag of the response
- from_mem_reg_addr  out  5  GPR of the response
- mem_read_data  out  32  read data

Behaviour:
- Clock is clk. Reset is rst, asynchronous and active-high.
- Reset values:
  - to_mem_ready = 0 while rst is high; it may assert in the first cycle after rst deasserts.
  - from_mem_valid = 0; from_mem_rs_id, from_mem_reg_addr and mem_read_data = 0.
  - Read pipeline and FIFO cleared; outstanding counter = 0.
  - Memory array contents are not reset.
- Word index = mem_address[30-log2(MEM_WORDS) : 29]. Upper address bits are ignored, so addresses wrap modulo MEM_WORDS*4.
- Write: on an accepted request with mem_write_en != 0, each enabled byte is updated at that clock edge. Writes produce no response.
- Read: on an accepted request with mem_read_en != 0:
  - The word is sampled at the accept edge.
  - Bytes whose read_en bit is 0 are returned as 0x00.
  - The entry enters a READ_LATENCY-deep shift pipeline together with rs_id and reg_addr.
  - At pipeline exit the entry is pushed into the response FIFO.
- A request with both enables zero is accepted and ignored.
- A request with both enables nonzero is read-first: the response carries the pre-write word, and the write still takes effect.
- Read-after-write to the same word in a later cycle returns the new data.
- Ordering: responses are strictly in acceptance order; the FIFO is first-word-fall-through.
- Outstanding counter:
  - outstanding = reads in pipeline + FIFO occupancy.
  - +1 on an accepted read; -1 on a response handshake; unchanged if both happen in the same cycle.
- Flow control:
  - to_mem_ready = (outstanding < RESP_DEPTH), applied to all requests (reads and writes alike) to preserve ordering.
  - The FIFO therefore never overflows; a push into a full FIFO is an assertion failure.
- Backpressure:
  - While from_mem_ready = 0, the response outputs are held stable and from_mem_valid stays 1.
  - The pipeline keeps advancing into the FIFO.
- FIFO full with simultaneous pop and push: both are performed and occupancy is unchanged.
- Throughput: one request per cycle when credits are available; one response per cycle.
- Reset mid-operation: all in-flight reads and queued responses are dropped. Writes already accepted remain in memory.

Decomposition:
- Shared package ppc_types gains mem_req_t (address, write_en, write_data, read_en, rs_id, reg_addr) and mem_resp_t (rs_id, reg_addr, data).
- mem_req_t and mem_resp_t are parameterised by a package constant DEFAULT_RS_ID_WIDTH.
- One sub-module, response_fifo: a synchronous FWFT FIFO with parameters DEPTH and DATA_TYPE, ports push/pop/full/empty/count, async active-high reset.
- Memory array, read pipeline and credit logic stay in data_mem_controller.

Test Plan:
1. Write 0xDEADBEEF with write_en=1111 to address 0x10, then read 0x10 with read_en=1111, rs_id=3, reg_addr=7 → response 0xDEADBEEF, rs_id=3, reg_addr=7, READ_LATENCY cycles after accept.
2. Byte merge: write 0x11223344 (1111), then write 0xAA000000 with write_en=1000, then read with read_en=0011 → data 0x00003344; a subsequent read with 1111 returns 0xAA223344.
3. Backpressure: hold from_mem_ready=0 and issue 6 reads (RESP_DEPTH=4) → exactly 4 accepted, to_mem_ready=0 afterwards, response outputs stable. Release ready → 4 responses in issue order, then the remaining 2 are accepted.
4. Read-first: a single request with write_en=1111, data 0x55555555 and read_en=1111 on a word holding 0x12345678 → response 0x12345678; a later read returns 0x55555555.
5. Wrap: with MEM_WORDS=1024, write to 0x0000_1004, then read 0x0000_0004 → same data returned.
6. Reset mid-operation: 3 reads outstanding, assert rst asynchronously between edges → from_mem_valid drops immediately, no stale responses after release, and earlier writes remain readable.

Source files
------------

// File: rtl/data_mem_controller_pkg.sv
// Shared ppc_types package: memory request/response payloads and byte-lane helpers.
// Data, address and enable vectors use big-endian numbering (bit 0 is the MSB).
package ppc_types;

  localparam int unsigned DEFAULT_RS_ID_WIDTH = 5;
  localparam int unsigned REG_ADDR_WIDTH      = 5;
  localparam int unsigned XLEN                = 32;
  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned BYTES               = XLEN / BYTE_W;

  typedef struct packed {
    logic [0:XLEN-1]                  address;
    logic [0:BYTES-1]                 write_en;
    logic [0:XLEN-1]                  write_data;
    logic [0:BYTES-1]                 read_en;
    logic [DEFAULT_RS_ID_WIDTH-1:0]   rs_id;
    logic [REG_ADDR_WIDTH-1:0]        reg_addr;
  } mem_req_t;

  typedef struct packed {
    logic [DEFAULT_RS_ID_WIDTH-1:0]   rs_id;
    logic [REG_ADDR_WIDTH-1:0]        reg_addr;
    logic [0:XLEN-1]                  data;
  } mem_resp_t;

  // Zero every byte lane whose enable bit is clear.
  function automatic logic [0:XLEN-1] mask_bytes(input logic [0:XLEN-1] word,
                                                 input logic [0:BYTES-1] en);
    logic [0:XLEN-1] r;
    r = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (en[i]) r[BYTE_W*i +: BYTE_W] = word[BYTE_W*i +: BYTE_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_mem_controller_response_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible on pop_data
// whenever empty is low. Simultaneous push and pop on a full FIFO are both honoured.
module response_fifo #(
  parameter int unsigned DEPTH     = 4,
  parameter type         DATA_TYPE = logic,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  DATA_TYPE         push_data,
  input  logic             pop,
  output DATA_TYPE         pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  DATA_TYPE         mem_q [DEPTH];
  DATA_TYPE         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = next_ptr(rd_ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Upstream credit logic must never let a push land on a full FIFO without a pop.
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
    else $error("response_fifo: push into full FIFO");

endmodule

// File: rtl/data_mem_controller.sv
// On-chip byte-writable data memory behind the load/store unit with a fixed-latency
// read pipeline and a credit-limited, in-order response FIFO.
module data_mem_controller
  import ppc_types::*;
#(
  parameter int unsigned RS_ID_WIDTH  = 5,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RESP_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   to_mem_valid,
  output logic                   to_mem_ready,
  input  logic [RS_ID_WIDTH-1:0] to_mem_rs_id,
  input  logic [4:0]             to_mem_reg_addr,
  input  logic [0:31]            mem_address,
  input  logic [0:3]             mem_write_en,
  input  logic [0:31]            mem_write_data,
  input  logic [0:3]             mem_read_en,
  output logic                   from_mem_valid,
  input  logic                   from_mem_ready,
  output logic [RS_ID_WIDTH-1:0] from_mem_rs_id,
  output logic [4:0]             from_mem_reg_addr,
  output logic [0:31]            mem_read_data
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned OUT_W = $clog2(RESP_DEPTH + 1);

  mem_req_t                 req;
  logic [IDX_W-1:0]         word_idx;
  logic                     accept, rd_accept, wr_accept, resp_pop;
  logic [0:XLEN-1]          mem_q [MEM_WORDS];

  logic [READ_LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
  mem_resp_t                pipe_q [READ_LATENCY];
  mem_resp_t                pipe_d [READ_LATENCY];

  logic [OUT_W-1:0]         outstanding_q, outstanding_d;
  logic                     ready_q, ready_d;

  mem_resp_t                fifo_head;
  logic                     fifo_full, fifo_empty;
  logic [OUT_W-1:0]         fifo_count;
  logic                     unused_ok;

  always_comb begin
    req = '{address:    mem_address,
            write_en:   mem_write_en,
            write_data: mem_write_data,
            read_en:    mem_read_en,
            rs_id:      DEFAULT_RS_ID_WIDTH'(to_mem_rs_id),
            reg_addr:   to_mem_reg_addr};
  end

  // Word index in big-endian bit numbering; upper address bits wrap.
  assign word_idx  = req.address[30-IDX_W:29];
  assign accept    = to_mem_valid && ready_q;
  assign rd_accept = accept && (req.read_en != '0);
  assign wr_accept = accept && (req.write_en != '0);
  assign resp_pop  = from_mem_valid && from_mem_ready;
  assign unused_ok = ^{req.address[0:29-IDX_W], req.address[30:31], fifo_full, fifo_count};

  // Memory array is not reset; byte lanes update on the accept edge.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < BYTES; i++) begin
        if (req.write_en[i])
          mem_q[word_idx][BYTE_W*i +: BYTE_W] <= req.write_data[BYTE_W*i +: BYTE_W];
      end
    end
  end

  // Read samples the pre-write word, so a combined read/write is read-first.
  always_comb begin
    pipe_vld_d    = {pipe_vld_q[READ_LATENCY-1:0], rd_accept};
    pipe_vld_d[0] = rd_accept;
    pipe_d[0]     = '{rs_id:    req.rs_id,
                      reg_addr: req.reg_addr,
                      data:     mask_bytes(mem_q[word_idx], req.read_en)};
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_d[i]     = pipe_q[i-1];
    end
    outstanding_d = outstanding_q + OUT_W'(rd_accept) - OUT_W'(resp_pop);
    ready_d       = (outstanding_d < OUT_W'(RESP_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q    <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
      outstanding_q <= '0;
      ready_q       <= 1'b0;
    end else begin
      pipe_vld_q    <= pipe_vld_d;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= pipe_d[i];
      outstanding_q <= outstanding_d;
      ready_q       <= ready_d;
    end
  end

  response_fifo #(
    .DEPTH     (RESP_DEPTH),
    .DATA_TYPE (mem_resp_t)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_vld_q[READ_LATENCY-1]),
    .push_data (pipe_q[READ_LATENCY-1]),
    .pop       (resp_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign to_mem_ready      = ready_q;
  assign from_mem_valid    = !fifo_empty;
  assign from_mem_rs_id    = RS_ID_WIDTH'(fifo_head.rs_id);
  assign from_mem_reg_addr = fifo_head.reg_addr;
  assign mem_read_data     = fifo_head.data;

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller: write/read, byte lanes, credits and
// backpressure, read-first, address wrap and mid-operation reset.
module tb_data_mem_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        to_mem_valid = 1'b0;
  logic        to_mem_ready;
  logic [4:0]  to_mem_rs_id = '0;
  logic [4:0]  to_mem_reg_addr = '0;
  logic [0:31] mem_address = '0;
  logic [0:3]  mem_write_en = '0;
  logic [0:31] mem_write_data = '0;
  logic [0:3]  mem_read_en = '0;
  logic        from_mem_valid;
  logic        from_mem_ready = 1'b1;
  logic [4:0]  from_mem_rs_id;
  logic [4:0]  from_mem_reg_addr;
  logic [0:31] mem_read_data;

  int errs = 0;
  int checks = 0;

  data_mem_controller #(
    .RS_ID_WIDTH (5),
    .MEM_WORDS   (1024),
    .READ_LATENCY(1),
    .RESP_DEPTH  (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .to_mem_valid     (to_mem_valid),
    .to_mem_ready     (to_mem_ready),
    .to_mem_rs_id     (to_mem_rs_id),
    .to_mem_reg_addr  (to_mem_reg_addr),
    .mem_address      (mem_address),
    .mem_write_en     (mem_write_en),
    .mem_write_data   (mem_write_data),
    .mem_read_en      (mem_read_en),
    .from_mem_valid   (from_mem_valid),
    .from_mem_ready   (from_mem_ready),
    .from_mem_rs_id   (from_mem_rs_id),
    .from_mem_reg_addr(from_mem_reg_addr),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                      input logic [3:0] re, input logic [4:0] rs, input logic [4:0] ra);
    int n;
    mem_address     = addr;
    mem_write_en    = we;
    mem_write_data  = wd;
    mem_read_en     = re;
    to_mem_rs_id    = rs;
    to_mem_reg_addr = ra;
    to_mem_valid    = 1'b1;
    n = 0;
    while (!to_mem_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("req_timeout", 32'(to_mem_ready), 32'd1);
    @(negedge clk);
    to_mem_valid = 1'b0;
    mem_write_en = '0;
    mem_read_en  = '0;
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] data,
                             input logic [4:0] rs, input logic [4:0] ra);
    int n;
    n = 0;
    while (!from_mem_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(from_mem_valid), 32'd1);
    chk({tag, "_data"}, mem_read_data, data);
    chk({tag, "_rs"}, 32'(from_mem_rs_id), 32'(rs));
    chk({tag, "_ra"}, 32'(from_mem_reg_addr), 32'(ra));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, r;
    logic acc;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(to_mem_ready), 32'd0);
    chk("rst_valid", 32'(from_mem_valid), 32'd0);
    chk("rst_data", mem_read_data, 32'd0);
    chk("rst_rs", 32'(from_mem_rs_id), 32'd0);
    chk("rst_ra", 32'(from_mem_reg_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(to_mem_ready), 32'd1);

    // 1: write then read, latency check
    send(32'h10, 4'b1111, 32'hDEADBEEF, 4'b0000, 5'd0, 5'd0);
    send(32'h10, 4'b0000, 32'h0, 4'b1111, 5'd3, 5'd7);
    chk("t1_in_pipe", 32'(from_mem_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(from_mem_valid), 32'd1);
    chk("t1_data", mem_read_data, 32'hDEADBEEF);
    chk("t1_rs", 32'(from_mem_rs_id), 32'd3);
    chk("t1_ra", 32'(from_mem_reg_addr), 32'd7);
    @(negedge clk);
    chk("t1_popped", 32'(from_mem_valid), 32'd0);

    // 2: byte merge and masked read (enable bit 0 = MSB byte)
    send(32'h20, 4'b1111, 32'h11223344, 4'b0000, 5'd0, 5'd0);
    send(32'h20, 4'b1000, 32'hAA000000, 4'b0000, 5'd0, 5'd0);
    send(32'h20, 4'b0000, 32'h0, 4'b0011, 5'd1, 5'd2);
    expect_resp("t2_mask", 32'h00003344, 5'd1, 5'd2);
    send(32'h20, 4'b0000, 32'h0, 4'b1111, 5'd2, 5'd3);
    expect_resp("t2_full", 32'hAA223344, 5'd2, 5'd3);

    // Both enables zero: accepted, no response
    send(32'h20, 4'b0000, 32'h0, 4'b0000, 5'd4, 5'd4);
    repeat (3) begin
      chk("noop_no_resp", 32'(from_mem_valid), 32'd0);
      @(negedge clk);
    end

    // 3: backpressure and credits
    for (int i = 0; i < 6; i++)
      send(32'h40 + 32'(4 * i), 4'b1111, 32'hA0000000 + 32'(i), 4'b0000, 5'd0, 5'd0);
    from_mem_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      mem_address     = 32'h40 + 32'(4 * k);
      mem_read_en     = 4'b1111;
      to_mem_rs_id    = 5'(k);
      to_mem_reg_addr = 5'(k + 1);
      to_mem_valid    = 1'b1;
      acc = to_mem_ready;
      @(negedge clk);
      if (acc) k++;
    end
    chk("t3_accepted", 32'(k), 32'd4);
    chk("t3_ready_low", 32'(to_mem_ready), 32'd0);
    chk("t3_valid", 32'(from_mem_valid), 32'd1);
    chk("t3_head_data", mem_read_data, 32'hA0000000);
    repeat (3) @(negedge clk);
    chk("t3_stable_valid", 32'(from_mem_valid), 32'd1);
    chk("t3_stable_data", mem_read_data, 32'hA0000000);
    chk("t3_stable_rs", 32'(from_mem_rs_id), 32'd0);
    chk("t3_stable_ra", 32'(from_mem_reg_addr), 32'd1);
    from_mem_ready = 1'b1;
    r = 0;
    for (int c = 0; c < 30 && r < 6; c++) begin
      if (from_mem_valid) begin
        chk("t3_order_data", mem_read_data, 32'hA0000000 + 32'(r));
        chk("t3_order_rs", 32'(from_mem_rs_id), 32'(r));
        r++;
      end
      if (k < 6) begin
        mem_address     = 32'h40 + 32'(4 * k);
        mem_read_en     = 4'b1111;
        to_mem_rs_id    = 5'(k);
        to_mem_reg_addr = 5'(k + 1);
        to_mem_valid    = 1'b1;
      end else begin
        to_mem_valid = 1'b0;
        mem_read_en  = '0;
      end
      acc = to_mem_valid && to_mem_ready;
      @(negedge clk);
      if (acc) k++;
    end
    to_mem_valid = 1'b0;
    mem_read_en  = '0;
    chk("t3_all_accepted", 32'(k), 32'd6);
    chk("t3_all_responses", 32'(r), 32'd6);
    chk("t3_drained", 32'(from_mem_valid), 32'd0);

    // 4: read-first on combined read/write
    send(32'h80, 4'b1111, 32'h12345678, 4'b0000, 5'd0, 5'd0);
    send(32'h80, 4'b1111, 32'h55555555, 4'b1111, 5'd9, 5'd2);
    expect_resp("t4_old", 32'h12345678, 5'd9, 5'd2);
    send(32'h80, 4'b0000, 32'h0, 4'b1111, 5'd10, 5'd3);
    expect_resp("t4_new", 32'h55555555, 5'd10, 5'd3);

    // 5: address wrap modulo MEM_WORDS*4
    send(32'h0000_1004, 4'b1111, 32'hCAFEF00D, 4'b0000, 5'd0, 5'd0);
    send(32'h0000_0004, 4'b0000, 32'h0, 4'b1111, 5'd11, 5'd4);
    expect_resp("t5_wrap", 32'hCAFEF00D, 5'd11, 5'd4);

    // 6: asynchronous reset with reads outstanding
    send(32'h100, 4'b1111, 32'h0BADCAFE, 4'b0000, 5'd0, 5'd0);
    from_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(32'h40 + 32'(4 * i), 4'b0000, 32'h0, 4'b1111, 5'(20 + i), 5'd1);
    @(negedge clk);
    chk("t6_pending", 32'(from_mem_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid_drop", 32'(from_mem_valid), 32'd0);
    chk("t6_ready_drop", 32'(to_mem_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    from_mem_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t6_no_stale", 32'(from_mem_valid), 32'd0);
    end
    send(32'h100, 4'b0000, 32'h0, 4'b1111, 5'd12, 5'd5);
    expect_resp("t6_kept", 32'h0BADCAFE, 5'd12, 5'd5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
